// File: rtl/mvm_axis_sequencer.sv
//------------------------------------------------------------------------------
// mvm_axis_sequencer: frames command + raw data words into multi-beat AXIS
// bursts carrying the MVM tuser encoding {mask, op, rf_addr}.
// Optional statistics counters are enabled with the MVM_SEQ_STATS_EN macro.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mvm_axis_sequencer #(
   parameter int DATAW   = 512,
   parameter int BYTEW   = 8,
   parameter int DESTW   = 12,
   parameter int RFADDRW = 9,
   parameter int OPW     = 2,
   parameter int MASKW   = 64,
   parameter int USERW   = 75,
   parameter int LENW    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [OPW-1:0]     cmd_op,
   input  logic [RFADDRW-1:0] cmd_addr,
   input  logic [MASKW-1:0]   cmd_mask,
   input  logic [DESTW-1:0]   cmd_dest,
   input  logic [LENW-1:0]    cmd_len,
   input  logic               data_valid,
   output logic               data_ready,
   input  logic [DATAW-1:0]   data_in,
   output logic               axis_tx_tvalid,
   input  logic               axis_tx_tready,
   output logic [DATAW-1:0]   axis_tx_tdata,
   output logic [USERW-1:0]   axis_tx_tuser,
   output logic [DESTW-1:0]   axis_tx_tdest,
   output logic               axis_tx_tlast,
   output logic [BYTEW-1:0]   axis_tx_tkeep,
   output logic [BYTEW-1:0]   axis_tx_tstrb,
   output logic               busy,
   output logic [31:0]        beats_sent,
   output logic [31:0]        stall_cycles
);

   localparam logic [1:0]     c_IDLE        = 2'd0;
   localparam logic [1:0]     c_STREAM      = 2'd1;
   localparam logic [1:0]     c_DRAIN       = 2'd2;
   localparam logic [OPW-1:0] c_OP_RF_WRITE = OPW'(3);

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [OPW-1:0]     r_op;
   logic [RFADDRW-1:0] r_addr;
   logic [MASKW-1:0]   r_mask;
   logic [DESTW-1:0]   r_dest;
   logic [LENW-1:0]    r_len;
   logic [LENW-1:0]    r_beat;
   logic               r_tvalid;
   logic               r_tlast;
   logic [DATAW-1:0]   r_tdata;
   logic [USERW-1:0]   r_tuser;
   logic [DESTW-1:0]   r_tdest;
   logic               w_load;
   logic               w_fire;
   logic               w_last_beat;
   logic               w_cmd_accept;

   assign w_fire       = r_tvalid & axis_tx_tready;
   assign w_load       = data_valid & data_ready;
   assign w_last_beat  = (r_beat == r_len);
   assign w_cmd_accept = (r_state == c_IDLE) & cmd_valid;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= c_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:   if (cmd_valid)              w_state_next = c_STREAM;
         c_STREAM: if (w_load && w_last_beat)  w_state_next = c_DRAIN;
         c_DRAIN:  if (w_fire)                 w_state_next = c_IDLE;
         default:                              w_state_next = c_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      data_ready = 1'b0;
      busy       = 1'b1;
      case (r_state)
         c_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         c_STREAM: data_ready = !r_tvalid || axis_tx_tready;
         default:  ;
      endcase
   end

   // Command fields; the RF address walks forward only for RF writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op   <= '0;
         r_addr <= '0;
         r_mask <= '0;
         r_dest <= '0;
         r_len  <= '0;
         r_beat <= '0;
      end else if (w_cmd_accept) begin
         r_op   <= cmd_op;
         r_addr <= cmd_addr;
         r_mask <= cmd_mask;
         r_dest <= cmd_dest;
         r_len  <= cmd_len;
         r_beat <= '0;
      end else if (w_load) begin
         r_beat <= r_beat + LENW'(1);
         if (r_op == c_OP_RF_WRITE) r_addr <= r_addr + RFADDRW'(1);
      end
   end

   // Output register: a load in the same cycle as a handshake replaces it in place.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
         r_tuser  <= '0;
         r_tdest  <= '0;
      end else if (w_load) begin
         r_tvalid <= 1'b1;
         r_tlast  <= w_last_beat;
         r_tdata  <= data_in;
         r_tuser  <= {r_mask, r_op, r_addr};
         r_tdest  <= r_dest;
      end else if (w_fire) begin
         r_tvalid <= 1'b0;
      end
   end

   assign axis_tx_tvalid = r_tvalid;
   assign axis_tx_tlast  = r_tlast;
   assign axis_tx_tdata  = r_tdata;
   assign axis_tx_tuser  = r_tuser;
   assign axis_tx_tdest  = r_tdest;
   assign axis_tx_tkeep  = r_tvalid ? {BYTEW{1'b1}} : {BYTEW{1'b0}};
   assign axis_tx_tstrb  = r_tvalid ? {BYTEW{1'b1}} : {BYTEW{1'b0}};

`ifdef MVM_SEQ_STATS_EN
   logic [31:0] r_beats_sent;
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_beats_sent   <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_fire && (r_beats_sent != 32'hFFFF_FFFF))
            r_beats_sent <= r_beats_sent + 32'd1;
         if (r_tvalid && !axis_tx_tready && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign beats_sent   = r_beats_sent;
   assign stall_cycles = r_stall_cycles;
`else
   assign beats_sent   = 32'd0;
   assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire
